// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch controller between PC and I-cache
// Issues one outstanding fetch at a time and holds the returned word for stage2.
module imem_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_2000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_in,
    input  logic        redirect,
    input  logic        dec_ready,
    output logic        icache_req_valid,
    input  logic        icache_req_ready,
    output logic [31:0] icache_req_addr,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        stall_pc
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    logic        inst_valid_r;
    logic        accept;

    assign accept = icache_req_valid & icache_req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // Redirect overrides every other transition.
    always_comb begin
        state_next = state;
        case (state)
            REQ: begin
                if (!redirect && icache_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_next = icache_resp_valid ? REQ : DROP;
                end else if (icache_resp_valid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect || dec_ready) begin
                    state_next = REQ;
                end
            end
            DROP: begin
                if (!redirect && icache_resp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    always_comb begin
        icache_req_valid = (state == REQ) & ~redirect;
        icache_req_addr  = pc_in;
        stall_pc         = ~redirect & ~((state == REQ) & icache_req_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r         <= PC_RESET;
            inst_r       <= NOP;
            inst_pc_r    <= PC_RESET;
            inst_valid_r <= 1'b0;
        end else begin
            if (accept) begin
                pc_r <= pc_in;
            end
            if (state == WAIT && icache_resp_valid && !redirect) begin
                inst_r       <= icache_resp_data;
                inst_pc_r    <= pc_r;
                inst_valid_r <= 1'b1;
            end
            // inst_pc is left alone so it keeps naming the last delivered word.
            if (state == HOLD && (redirect || dec_ready)) begin
                inst_r       <= NOP;
                inst_valid_r <= 1'b0;
            end
        end
    end

    assign inst_valid = inst_valid_r;
    assign inst_out   = inst_valid_r ? inst_r : NOP;
    assign inst_pc    = inst_pc_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl
// Stimulus pushes expected fetch addresses and delivered words; a monitor pops them.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_in;
    logic        redirect;
    logic        dec_ready;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        stall_pc;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] addr_q[$];
    logic [63:0] inst_q[$];

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pc_in             (pc_in),
        .redirect          (redirect),
        .dec_ready         (dec_ready),
        .icache_req_valid  (icache_req_valid),
        .icache_req_ready  (icache_req_ready),
        .icache_req_addr   (icache_req_addr),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_data  (icache_resp_data),
        .inst_valid        (inst_valid),
        .inst_out          (inst_out),
        .inst_pc           (inst_pc),
        .stall_pc          (stall_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted request and every delivered word is checked in order.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (icache_req_valid && icache_req_ready) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_req", icache_req_addr, 32'hFFFF_FFFF);
                end else begin
                    chk("req_addr", icache_req_addr, addr_q.pop_front());
                end
            end
            if (inst_valid && dec_ready && !redirect) begin
                if (inst_q.size() == 0) begin
                    chk("unexpected_inst", inst_out, 32'hFFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = inst_q.pop_front();
                    chk("inst_out", inst_out, e[63:32]);
                    chk("inst_pc", inst_pc, e[31:0]);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        pc_in = 32'h2000;
        redirect = 1'b0;
        dec_ready = 1'b0;
        icache_req_ready = 1'b0;
        icache_resp_valid = 1'b0;
        icache_resp_data = 32'h0;
        repeat (2) step();
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst_out", inst_out, 32'h13);
        chk("rst_inst_pc", inst_pc, 32'h2000);
        reset_n = 1'b1;
        step();

        // Basic fetch: accept c0, response c2, word visible c3.
        icache_req_ready = 1'b1;
        addr_q.push_back(32'h2000);
        mid();
        chk("c0_req_valid", {31'b0, icache_req_valid}, 32'd1);
        chk("c0_stall", {31'b0, stall_pc}, 32'd0);
        step();
        icache_req_ready = 1'b0;
        pc_in = 32'h2004;
        mid();
        chk("c1_req_valid", {31'b0, icache_req_valid}, 32'd0);
        chk("c1_stall", {31'b0, stall_pc}, 32'd1);
        step();
        icache_resp_valid = 1'b1;
        icache_resp_data = 32'h0050_0093;
        inst_q.push_back({32'h0050_0093, 32'h2000});
        mid();
        chk("c2_inst_valid", {31'b0, inst_valid}, 32'd0);
        step();
        icache_resp_valid = 1'b0;

        // Backpressure in HOLD for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("hold_valid", {31'b0, inst_valid}, 32'd1);
            chk("hold_inst", inst_out, 32'h0050_0093);
            chk("hold_pc", inst_pc, 32'h2000);
            chk("hold_stall", {31'b0, stall_pc}, 32'd1);
            chk("hold_no_req", {31'b0, icache_req_valid}, 32'd0);
            step();
        end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        mid();
        chk("rel_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rel_inst_out", inst_out, 32'h13);
        chk("rel_inst_pc_kept", inst_pc, 32'h2000);
        chk("rel_req_valid", {31'b0, icache_req_valid}, 32'd1);

        // Cache not ready for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            mid();
            chk("nr_req_valid", {31'b0, icache_req_valid}, 32'd1);
            chk("nr_addr", icache_req_addr, 32'h2004);
            chk("nr_stall", {31'b0, stall_pc}, 32'd1);
        end
        step();
        icache_req_ready = 1'b1;
        addr_q.push_back(32'h2004);
        mid();
        chk("nr_accept_stall", {31'b0, stall_pc}, 32'd0);
        step();

        // Redirect in WAIT without response -> DROP, orphan discarded.
        icache_req_ready = 1'b0;
        pc_in = 32'h2008;
        redirect = 1'b1;
        mid();
        chk("rw_stall", {31'b0, stall_pc}, 32'd0);
        chk("rw_req_valid", {31'b0, icache_req_valid}, 32'd0);
        step();
        redirect = 1'b0;
        pc_in = 32'h3000;
        icache_resp_valid = 1'b1;
        icache_resp_data = 32'hDEAD_BEEF;
        mid();
        chk("drop_req_valid", {31'b0, icache_req_valid}, 32'd0);
        chk("drop_stall", {31'b0, stall_pc}, 32'd1);
        step();
        icache_resp_valid = 1'b0;
        mid();
        chk("drop_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("drop_inst_out", inst_out, 32'h13);
        chk("drop_req_valid2", {31'b0, icache_req_valid}, 32'd1);
        chk("drop_addr", icache_req_addr, 32'h3000);

        // Fetch with k=1, then redirect in HOLD with dec_ready high.
        icache_req_ready = 1'b1;
        addr_q.push_back(32'h3000);
        step();
        icache_req_ready = 1'b0;
        pc_in = 32'h3004;
        icache_resp_valid = 1'b1;
        icache_resp_data = 32'h0010_0113;
        step();
        icache_resp_valid = 1'b0;
        mid();
        chk("k1_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("k1_inst_out", inst_out, 32'h0010_0113);
        chk("k1_inst_pc", inst_pc, 32'h3000);
        step();
        redirect = 1'b1;
        dec_ready = 1'b1;
        mid();
        chk("rh_stall", {31'b0, stall_pc}, 32'd0);
        step();
        redirect = 1'b0;
        dec_ready = 1'b0;
        pc_in = 32'h4000;
        mid();
        chk("rh_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rh_inst_out", inst_out, 32'h13);
        chk("rh_req_valid", {31'b0, icache_req_valid}, 32'd1);

        // Redirect in REQ suppresses the request; stray response is ignored.
        icache_req_ready = 1'b1;
        redirect = 1'b1;
        icache_resp_valid = 1'b1;
        mid();
        chk("rr_req_valid", {31'b0, icache_req_valid}, 32'd0);
        chk("rr_stall", {31'b0, stall_pc}, 32'd0);
        step();
        redirect = 1'b0;
        icache_resp_valid = 1'b0;
        addr_q.push_back(32'h4000);
        mid();
        chk("rr_still_req", {31'b0, icache_req_valid}, 32'd1);
        chk("rr_no_inst", {31'b0, inst_valid}, 32'd0);
        step();

        // Redirect in WAIT coinciding with response -> straight back to REQ.
        icache_req_ready = 1'b0;
        redirect = 1'b1;
        icache_resp_valid = 1'b1;
        icache_resp_data = 32'h1111_1111;
        step();
        redirect = 1'b0;
        icache_resp_valid = 1'b0;
        pc_in = 32'h5000;
        mid();
        chk("rwr_req_valid", {31'b0, icache_req_valid}, 32'd1);
        chk("rwr_inst_valid", {31'b0, inst_valid}, 32'd0);

        // Reset while in WAIT.
        icache_req_ready = 1'b1;
        addr_q.push_back(32'h5000);
        step();
        icache_req_ready = 1'b0;
        pc_in = 32'h5004;
        mid();
        chk("pre_rst_wait", {31'b0, icache_req_valid}, 32'd0);
        chk("pre_rst_pc", inst_pc, 32'h3000);
        step();
        reset_n = 1'b0;
        #1;
        chk("mrst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("mrst_inst_out", inst_out, 32'h13);
        chk("mrst_inst_pc", inst_pc, 32'h2000);
        step();
        reset_n = 1'b1;
        mid();
        chk("post_rst_req", {31'b0, icache_req_valid}, 32'd1);
        chk("post_rst_addr", icache_req_addr, 32'h5004);
        step();

        chk("addr_q_empty", addr_q.size(), 32'd0);
        chk("inst_q_empty", inst_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
